// File: rtl/demux2_stream_if.sv
// demux2_stream_if: producer side and two consumer lanes of the demux2_stream handshake
interface demux2_stream_if #(parameter int WIDTH = 1);
  logic             io_sel;
  logic             io_in_valid;
  logic             io_in_ready;
  logic [WIDTH-1:0] io_in_bits;
  logic             io_out0_valid;
  logic             io_out0_ready;
  logic [WIDTH-1:0] io_out0_bits;
  logic             io_out1_valid;
  logic             io_out1_ready;
  logic [WIDTH-1:0] io_out1_bits;
  modport master (
    output io_sel, io_in_valid, io_in_bits, io_out0_ready, io_out1_ready,
    input  io_in_ready, io_out0_valid, io_out0_bits, io_out1_valid, io_out1_bits
  );
  modport slave (
    input  io_sel, io_in_valid, io_in_bits, io_out0_ready, io_out1_ready,
    output io_in_ready, io_out0_valid, io_out0_bits, io_out1_valid, io_out1_bits
  );
endinterface

// File: rtl/demux2_stream.sv
// demux2_stream: registered 1-to-2 stream demux, 2-entry FIFO per lane; DEMUX2_COUNT_EN adds per-lane delivered-beat counters
module demux2_stream #(
  parameter int WIDTH = 1
`ifdef DEMUX2_COUNT_EN
  , parameter int CNT_W = 8
`endif
) (
  input logic clk,
  input logic reset,
  demux2_stream_if.slave s
`ifdef DEMUX2_COUNT_EN
  , output logic [CNT_W-1:0] io_cnt0
  , output logic [CNT_W-1:0] io_cnt1
`endif
);
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} occ_e;
  logic [1:0] full, vld, enq, deq, rdy;
  logic [WIDTH-1:0] head [2];
  assign rdy = {s.io_out1_ready, s.io_out0_ready};
  // Ready looks only at registered occupancy, so a same-cycle dequeue cannot open a full lane
  assign s.io_in_ready = !full[s.io_sel];
  for (genvar l = 0; l < 2; l++) begin : g_lane
    occ_e occ_q, occ_d;
    logic wp_q, wp_d, rp_q, rp_d;
    logic [1:0][WIDTH-1:0] mem_q, mem_d;
    assign full[l] = occ_q == FULL;
    assign vld[l] = occ_q != EMPTY;
    assign enq[l] = s.io_in_valid && s.io_in_ready && (s.io_sel == 1'(l));
    assign deq[l] = vld[l] && rdy[l];
    assign head[l] = mem_q[rp_q];
    always_comb begin
      mem_d = mem_q;
      if (enq[l]) mem_d[wp_q] = s.io_in_bits;
      wp_d = wp_q ^ enq[l];
      rp_d = rp_q ^ deq[l];
      occ_d = (enq[l] && !deq[l]) ? ((occ_q == EMPTY) ? ONE : FULL) :
              (!enq[l] && deq[l]) ? ((occ_q == FULL) ? ONE : EMPTY) : occ_q;
    end
    always_ff @(posedge clk) begin
      if (reset) begin
        occ_q <= EMPTY;
        wp_q  <= 1'b0;
        rp_q  <= 1'b0;
        mem_q <= '0;
      end else begin
        occ_q <= occ_d;
        wp_q  <= wp_d;
        rp_q  <= rp_d;
        mem_q <= mem_d;
      end
    end
  end
  assign s.io_out0_valid = vld[0];
  assign s.io_out1_valid = vld[1];
  assign s.io_out0_bits  = head[0];
  assign s.io_out1_bits  = head[1];
`ifdef DEMUX2_COUNT_EN
  logic [CNT_W-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;
  assign cnt0_d = cnt0_q + CNT_W'(deq[0]);
  assign cnt1_d = cnt1_q + CNT_W'(deq[1]);
  always_ff @(posedge clk) begin
    cnt0_q <= reset ? '0 : cnt0_d;
    cnt1_q <= reset ? '0 : cnt1_d;
  end
  assign io_cnt0 = cnt0_q;
  assign io_cnt1 = cnt1_q;
`endif
endmodule

// File: tb/tb_demux2_stream.sv
// tb_demux2_stream: directed scenarios plus randomized traffic checked against a two-queue reference model
module tb_demux2_stream;
  localparam int W = 4;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int tests = 0;
  int fails = 0;
  logic [W-1:0] q0[$];
  logic [W-1:0] q1[$];
  always #5 clk = ~clk;
  demux2_stream_if #(.WIDTH(W)) ifc();
`ifdef DEMUX2_COUNT_EN
  logic [7:0] cnt0, cnt1, mc0, mc1;
  demux2_stream #(.WIDTH(W), .CNT_W(8)) dut (.clk(clk), .reset(reset), .s(ifc), .io_cnt0(cnt0), .io_cnt1(cnt1));
`else
  demux2_stream #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .s(ifc));
`endif

  task automatic set(input logic r, input logic sel, input logic v, input logic [W-1:0] b, input logic r0, input logic r1);
    @(negedge clk);
    reset = r;
    ifc.io_sel = sel;
    ifc.io_in_valid = v;
    ifc.io_in_bits = b;
    ifc.io_out0_ready = r0;
    ifc.io_out1_ready = r1;
    #1;
  endtask

  function automatic logic model_ready();
    return (ifc.io_sel ? q1.size() : q0.size()) < 2;
  endfunction

  task automatic step();
    logic r, sel, acc, d0, d1;
    logic [W-1:0] b;
    r = reset;
    sel = ifc.io_sel;
    b = ifc.io_in_bits;
    acc = ifc.io_in_valid && model_ready();
    d0 = ifc.io_out0_ready && q0.size() != 0;
    d1 = ifc.io_out1_ready && q1.size() != 0;
    @(posedge clk);
    if (r) begin
      q0.delete();
      q1.delete();
`ifdef DEMUX2_COUNT_EN
      mc0 = 0;
      mc1 = 0;
`endif
    end else begin
      if (d0) begin
        void'(q0.pop_front());
`ifdef DEMUX2_COUNT_EN
        mc0++;
`endif
      end
      if (d1) begin
        void'(q1.pop_front());
`ifdef DEMUX2_COUNT_EN
        mc1++;
`endif
      end
      if (acc && sel) q1.push_back(b);
      if (acc && !sel) q0.push_back(b);
    end
  endtask

  task automatic test_reset();
    set(1, 0, 0, 0, 1, 1); step();
    set(1, 0, 0, 0, 1, 1); step();
    set(0, 0, 0, 0, 0, 0);
    tests++; if (ifc.io_out0_valid !== 1'b0) begin fails++; $display("FAIL rst_v0: got %b exp 0", ifc.io_out0_valid); end
    tests++; if (ifc.io_out1_valid !== 1'b0) begin fails++; $display("FAIL rst_v1: got %b exp 0", ifc.io_out1_valid); end
    tests++; if (ifc.io_out0_bits !== '0) begin fails++; $display("FAIL rst_b0: got %h exp 0", ifc.io_out0_bits); end
    tests++; if (ifc.io_out1_bits !== '0) begin fails++; $display("FAIL rst_b1: got %h exp 0", ifc.io_out1_bits); end
    tests++; if (ifc.io_in_ready !== 1'b1) begin fails++; $display("FAIL rst_rdy_sel0: got %b exp 1", ifc.io_in_ready); end
    ifc.io_sel = 1'b1;
    #1;
    tests++; if (ifc.io_in_ready !== 1'b1) begin fails++; $display("FAIL rst_rdy_sel1: got %b exp 1", ifc.io_in_ready); end
    step();
  endtask

  task automatic test_basic();
    set(0, 0, 1, 1, 1, 1);
    tests++; if (ifc.io_in_ready !== 1'b1) begin fails++; $display("FAIL basic_rdy: got %b exp 1", ifc.io_in_ready); end
    step();
    set(0, 1, 1, 0, 1, 1);
    tests++; if ({ifc.io_out0_valid, ifc.io_out0_bits} !== {1'b1, 4'h1}) begin fails++; $display("FAIL basic_lane0: got %b/%h exp 1/1", ifc.io_out0_valid, ifc.io_out0_bits); end
    tests++; if (ifc.io_out1_valid !== 1'b0) begin fails++; $display("FAIL basic_lane1_early: got %b exp 0", ifc.io_out1_valid); end
    step();
    set(0, 0, 0, 0, 1, 1);
    tests++; if (ifc.io_out0_valid !== 1'b0) begin fails++; $display("FAIL basic_lane0_once: got %b exp 0", ifc.io_out0_valid); end
    tests++; if ({ifc.io_out1_valid, ifc.io_out1_bits} !== {1'b1, 4'h0}) begin fails++; $display("FAIL basic_lane1: got %b/%h exp 1/0", ifc.io_out1_valid, ifc.io_out1_bits); end
    step();
    set(0, 0, 0, 0, 1, 1);
    tests++; if (ifc.io_out1_valid !== 1'b0) begin fails++; $display("FAIL basic_lane1_once: got %b exp 0", ifc.io_out1_valid); end
    step();
  endtask

  task automatic test_stall();
    set(0, 0, 1, 1, 0, 1); step();
    set(0, 0, 1, 0, 0, 1);
    tests++; if (ifc.io_in_ready !== 1'b1) begin fails++; $display("FAIL stall_rdy2: got %b exp 1", ifc.io_in_ready); end
    step();
    set(0, 0, 1, 1, 0, 1);
    tests++; if (ifc.io_in_ready !== 1'b0) begin fails++; $display("FAIL stall_full: got %b exp 0", ifc.io_in_ready); end
    step();
    set(0, 0, 1, 1, 1, 1);
    tests++; if (ifc.io_in_ready !== 1'b0) begin fails++; $display("FAIL stall_full_deq: got %b exp 0", ifc.io_in_ready); end
    tests++; if ({ifc.io_out0_valid, ifc.io_out0_bits} !== {1'b1, 4'h1}) begin fails++; $display("FAIL stall_head1: got %b/%h exp 1/1", ifc.io_out0_valid, ifc.io_out0_bits); end
    step();
    set(0, 0, 1, 1, 1, 1);
    tests++; if (ifc.io_in_ready !== 1'b1) begin fails++; $display("FAIL stall_reopen: got %b exp 1", ifc.io_in_ready); end
    tests++; if (ifc.io_out0_bits !== 4'h0) begin fails++; $display("FAIL stall_head2: got %h exp 0", ifc.io_out0_bits); end
    step();
    set(0, 0, 0, 0, 1, 1);
    tests++; if ({ifc.io_out0_valid, ifc.io_out0_bits} !== {1'b1, 4'h1}) begin fails++; $display("FAIL stall_head3: got %b/%h exp 1/1", ifc.io_out0_valid, ifc.io_out0_bits); end
    step();
    set(0, 0, 0, 0, 1, 1);
    tests++; if (ifc.io_out0_valid !== 1'b0) begin fails++; $display("FAIL stall_drained: got %b exp 0", ifc.io_out0_valid); end
    step();
  endtask

  task automatic test_isolation();
    set(0, 0, 1, 4'h5, 0, 1); step();
    set(0, 0, 1, 4'hA, 0, 1); step();
    set(0, 1, 1, 4'h3, 0, 1);
    tests++; if (ifc.io_in_ready !== 1'b1) begin fails++; $display("FAIL iso_rdy1: got %b exp 1", ifc.io_in_ready); end
    step();
    set(0, 1, 1, 4'hC, 0, 1);
    tests++; if ({ifc.io_out1_valid, ifc.io_out1_bits} !== {1'b1, 4'h3}) begin fails++; $display("FAIL iso_l1_a: got %b/%h exp 1/3", ifc.io_out1_valid, ifc.io_out1_bits); end
    tests++; if (ifc.io_in_ready !== 1'b1) begin fails++; $display("FAIL iso_rdy2: got %b exp 1", ifc.io_in_ready); end
    step();
    set(0, 1, 0, 0, 0, 1);
    tests++; if ({ifc.io_out1_valid, ifc.io_out1_bits} !== {1'b1, 4'hC}) begin fails++; $display("FAIL iso_l1_b: got %b/%h exp 1/c", ifc.io_out1_valid, ifc.io_out1_bits); end
    step();
    set(0, 0, 1, 4'hE, 0, 1);
    tests++; if (ifc.io_in_ready !== 1'b0) begin fails++; $display("FAIL iso_l0_full: got %b exp 0", ifc.io_in_ready); end
    tests++; if ({ifc.io_out0_valid, ifc.io_out0_bits} !== {1'b1, 4'h5}) begin fails++; $display("FAIL iso_l0_held: got %b/%h exp 1/5", ifc.io_out0_valid, ifc.io_out0_bits); end
    tests++; if (ifc.io_out1_valid !== 1'b0) begin fails++; $display("FAIL iso_l1_empty: got %b exp 0", ifc.io_out1_valid); end
    step();
  endtask

  task automatic test_reset_mid();
    set(0, 1, 1, 4'h7, 0, 0); step();
    set(0, 1, 1, 4'h8, 0, 0); step();
    set(0, 1, 0, 0, 0, 0);
    tests++; if (ifc.io_in_ready !== 1'b0) begin fails++; $display("FAIL mid_l1_full: got %b exp 0", ifc.io_in_ready); end
    step();
    set(1, 1, 1, 4'hF, 1, 1); step();
    set(0, 0, 0, 0, 1, 1);
    tests++; if ({ifc.io_out0_valid, ifc.io_out1_valid} !== 2'b00) begin fails++; $display("FAIL mid_valids: got %b exp 00", {ifc.io_out0_valid, ifc.io_out1_valid}); end
    tests++; if ({ifc.io_out0_bits, ifc.io_out1_bits} !== '0) begin fails++; $display("FAIL mid_bits: got %h exp 0", {ifc.io_out0_bits, ifc.io_out1_bits}); end
    step();
    set(0, 1, 1, 4'h9, 1, 1);
    tests++; if ({ifc.io_out0_valid, ifc.io_out1_valid} !== 2'b00) begin fails++; $display("FAIL mid_no_stale: got %b exp 00", {ifc.io_out0_valid, ifc.io_out1_valid}); end
    step();
    set(0, 0, 0, 0, 1, 1);
    tests++; if ({ifc.io_out1_valid, ifc.io_out1_bits} !== {1'b1, 4'h9}) begin fails++; $display("FAIL mid_new: got %b/%h exp 1/9", ifc.io_out1_valid, ifc.io_out1_bits); end
    step();
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      set($urandom_range(0, 79) == 0, 1'($urandom), $urandom_range(0, 3) != 0, W'($urandom),
          $urandom_range(0, 3) < 1 + (i / 150), $urandom_range(0, 3) < 1 + ((i / 75) % 4));
      tests++; if (ifc.io_in_ready !== model_ready()) begin fails++; $display("FAIL rnd_rdy @%0d: got %b exp %b", i, ifc.io_in_ready, model_ready()); end
      tests++; if (ifc.io_out0_valid !== (q0.size() != 0)) begin fails++; $display("FAIL rnd_v0 @%0d: got %b exp %b", i, ifc.io_out0_valid, q0.size() != 0); end
      tests++; if (ifc.io_out1_valid !== (q1.size() != 0)) begin fails++; $display("FAIL rnd_v1 @%0d: got %b exp %b", i, ifc.io_out1_valid, q1.size() != 0); end
      if (q0.size() != 0) begin
        tests++; if (ifc.io_out0_bits !== q0[0]) begin fails++; $display("FAIL rnd_b0 @%0d: got %h exp %h", i, ifc.io_out0_bits, q0[0]); end
      end
      if (q1.size() != 0) begin
        tests++; if (ifc.io_out1_bits !== q1[0]) begin fails++; $display("FAIL rnd_b1 @%0d: got %h exp %h", i, ifc.io_out1_bits, q1[0]); end
      end
`ifdef DEMUX2_COUNT_EN
      tests++; if ({cnt0, cnt1} !== {mc0, mc1}) begin fails++; $display("FAIL rnd_cnt @%0d: got %0d/%0d exp %0d/%0d", i, cnt0, cnt1, mc0, mc1); end
`endif
      step();
    end
  endtask

`ifdef DEMUX2_COUNT_EN
  task automatic test_counters();
    set(1, 0, 0, 0, 1, 1); step();
    for (int i = 0; i < 256; i++) begin
      set(0, 0, 1, W'($urandom), 1, 1); step();
    end
    for (int i = 0; i < 3; i++) begin
      set(0, 1, 1, W'($urandom), 1, 1); step();
    end
    set(0, 0, 0, 0, 1, 1); step();
    set(0, 0, 0, 0, 1, 1); step();
    set(0, 0, 0, 0, 1, 1);
    tests++; if (cnt0 !== 8'd0) begin fails++; $display("FAIL cnt0_wrap: got %0d exp 0", cnt0); end
    tests++; if (cnt1 !== 8'd3) begin fails++; $display("FAIL cnt1: got %0d exp 3", cnt1); end
    step();
  endtask
`endif

  initial begin
    ifc.io_sel = 1'b0;
    ifc.io_in_valid = 1'b0;
    ifc.io_in_bits = '0;
    ifc.io_out0_ready = 1'b0;
    ifc.io_out1_ready = 1'b0;
`ifdef DEMUX2_COUNT_EN
    mc0 = 0;
    mc1 = 0;
`endif
    test_reset();
    test_basic();
    test_stall();
    test_isolation();
    test_reset_mid();
    test_random();
`ifdef DEMUX2_COUNT_EN
    test_counters();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/demux2_stream.md
Name: demux2_stream

Overview:
- Registered 1-to-2 stream demultiplexer; the inverse of the 2:1 mux.
- Routes each accepted input beat to output lane 0 or lane 1 according to io_sel sampled with the beat.
- Each lane has a 2-entry FIFO and a valid/ready handshake, so one stalled lane never corrupts or reorders the other.
- Sits between a single producer and two independent consumers.

Parameters:
- WIDTH, 1, payload width in bits.
- CNT_W, 8, width of the per-lane delivered-beat counters (used only with the optional feature).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- io_sel  input  1  lane select for the current input beat (0 = lane 0, 1 = lane 1).
- io_in_valid  input  1  producer has a beat.
- io_in_ready  output  1  block accepts the beat this cycle.
- io_in_bits  input  WIDTH  payload.
- io_out0_valid  output  1  lane 0 FIFO non-empty.
- io_out0_ready  input  1  lane 0 consumer accepts.
- io_out0_bits  output  WIDTH  lane 0 head payload.
- io_out1_valid  output  1  lane 1 FIFO non-empty.
- io_out1_ready  input  1  lane 1 consumer accepts.
- io_out1_bits  output  WIDTH  lane 1 head payload.
- io_cnt0  output  CNT_W  lane 0 delivered-beat count (only with DEMUX2_COUNT_EN).
- io_cnt1  output  CNT_W  lane 1 delivered-beat count (only with DEMUX2_COUNT_EN).

Behaviour:
- Per lane: 2-entry circular FIFO with a 1-bit write pointer, a 1-bit read pointer and a 2-bit occupancy count (0..2).
- Lane state is implied by occupancy: EMPTY(0), ONE(1), FULL(2).
- io_in_ready = !full[io_sel].
  - Depends only on registered occupancy and io_sel; no combinational path from io_outX_ready.
  - io_in_ready does not rise in a cycle where the selected lane is full, even if that lane dequeues in the same cycle.
- Enqueue: io_in_valid && io_in_ready writes io_in_bits into lane[io_sel] at the write pointer.
  - Write pointer increments mod 2.
  - Occupancy increments, unless that lane also dequeues the same cycle, in which case occupancy is unchanged.
- Dequeue: io_outX_valid && io_outX_ready advances lane X read pointer mod 2 and decrements occupancy.
- io_outX_valid = (occupancy_X != 0); io_outX_bits = entry at read pointer.
  - Both are registered state: no combinational input-to-output path.
- Latency:
  - A beat accepted at edge N appears on its lane output after edge N (valid in cycle N+1) if that lane was empty.
  - Otherwise it appears behind earlier beats.
- Ordering: strict FIFO within a lane; no ordering guarantee across lanes.
- Both lanes may dequeue in the same cycle. At most one lane enqueues per cycle.
- io_sel is ignored when io_in_valid = 0. io_in_ready still reflects the currently selected lane.
- Full boundary: with lane X at 2 entries and io_sel = X, io_in_ready = 0.
  - The beat is held by the producer and no state changes for that lane.
  - The other lane is unaffected.
- Empty boundary: with occupancy 0, io_outX_ready has no effect; pointers do not move.
- Pointer wrap: after 2 writes the write pointer returns to 0; data integrity holds across wrap.
- Reset (synchronous, active-high): while reset is high at a clock edge:
  - Pointers and occupancy are cleared.
  - Storage is cleared to 0.
  - io_out0_valid = io_out1_valid = 0; io_outX_bits = 0.
  - Counters are cleared to 0.
- Reset mid-operation: queued beats are discarded; no beat is presented after reset deasserts until a new enqueue.
- During reset cycles io_in_ready may show 1, but no enqueue is recorded.

Optional Feature:
- Macro: DEMUX2_COUNT_EN.
- Defined:
  - io_cnt0 and io_cnt1 exist.
  - Each increments by 1 on every completed dequeue of its lane (valid && ready).
  - Counters wrap modulo 2^CNT_W (e.g. 255 -> 0 with CNT_W = 8).
  - Counters reset to 0.
- Undefined: the ports and the counter logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then idle -> io_out0_valid = io_out1_valid = 0, bits = 0, io_in_ready = 1 for both io_sel values.
- Send 1 (sel = 0) then 0 (sel = 1), both consumers ready -> lane 0 outputs 1 in the cycle after the first accept; lane 1 outputs 0 in the cycle after the second; each valid for one cycle.
- io_out0_ready = 0; send 3 beats with sel = 0 (1, 0, 1) -> first two accepted, third stalls with io_in_ready = 0. Raise ready -> outputs 1, 0, then the third beat 1 after it is accepted; order preserved.
- Lane 0 full and stalled; send sel = 1 beats 1, 1 -> io_in_ready = 1, lane 1 delivers both while lane 0 holds its 2 entries unchanged.
- Lane 1 holding 2 entries, assert reset for one cycle mid-stream -> both valids 0 after the reset edge; no stale beat reappears; the next enqueue delivers correctly.
- With DEMUX2_COUNT_EN, CNT_W = 8: deliver 256 beats to lane 0 and 3 to lane 1 -> io_cnt0 = 0 (wrapped), io_cnt1 = 3.
